// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares the single write port of the UART TX FIFO between NUM_REQ byte-stream
// requesters (CPU register path, debug console, DMA, ...). Once granted, a
// requester keeps the port until it delivers a byte flagged `last`, or until
// MAX_BURST beats have moved. Bytes from different packets therefore never
// interleave, except when a long packet is cut by the burst limit. The winner
// is chosen round-robin, and the search starts one past the last owner.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no grant held; scan req_valid_i from rr_ptr and latch a winner
// GRANT  | grant_idx owns the FIFO port; beats pass straight through
//
// Ports
//   clk_i        system clock
//   srst_i       synchronous reset, active-high; also blocks beats while high
//   req_data_i   packed requester data, requester k at [k*ELEM_WIDTH +: ELEM_WIDTH]
//   req_valid_i  per-requester valid
//   req_last_i   per-requester end-of-packet, qualified by valid
//   req_ready_o  per-requester ready (only the granted bit can be high)
//   out_data_o   data towards the TX FIFO
//   out_valid_o  valid towards the TX FIFO
//   out_ready_i  TX FIFO can accept
//   grant_o      one-hot current owner, zero when idle (registered)
//   busy_o       a grant is held (registered)
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ELEM_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk_i,
    input  logic                          srst_i,
    input  logic [NUM_REQ*ELEM_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [ELEM_WIDTH-1:0]         out_data_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic [ELEM_WIDTH-1:0] req_data_arr [NUM_REQ];

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand_idx;

    logic beat;
    logic rel_grant;

    // Unpack the flat data bus so the granted lane can be selected by index.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_data_arr[k] = req_data_i[k*ELEM_WIDTH +: ELEM_WIDTH];
    end

    // Round-robin search: scan rr_ptr, rr_ptr+1, ... with wrap. The modulo
    // keeps the wrap correct when NUM_REQ is not a power of two.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_idx = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!pick_found && req_valid_i[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        beat_cnt_d  = beat_cnt_q;
        beat        = 1'b0;
        rel_grant   = 1'b0;
        out_data_o  = '0;
        out_valid_o = 1'b0;
        req_ready_o = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_idx_d = pick_idx;
                    beat_cnt_d  = '0;
                    state_d     = ST_GRANT;
                end
            end

            ST_GRANT: begin
                // Valid and ready are masked during reset so that no byte is
                // handed over in a cycle that is about to clear the grant.
                out_data_o               = req_data_arr[grant_idx_q];
                out_valid_o              = req_valid_i[grant_idx_q] & ~srst_i;
                req_ready_o[grant_idx_q] = out_ready_i & ~srst_i;

                beat = req_valid_i[grant_idx_q] & out_ready_i & ~srst_i;

                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    // beat_cnt_q counts beats already moved, so this beat is
                    // number MAX_BURST when it equals MAX_BURST-1.
                    rel_grant  = req_last_i[grant_idx_q] || (beat_cnt_q == BURST_LAST);
                end

                if (rel_grant) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // grant_o / busy_o decode registered state only, so they carry no
    // combinational path from out_ready_i.
    always_comb begin
        grant_o = '0;
        busy_o  = 1'b0;
        if (state_q == ST_GRANT) begin
            grant_o[grant_idx_q] = 1'b1;
            busy_o               = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Each requester owns a queue of {last, byte} entries. Every cycle the bench
// presents the queue heads, with random or scripted valid and ready. A
// transaction-level model tracks the current owner, the number of beats moved
// under the grant and the next search start. It predicts grant/busy/valid/
// data/ready, and it pops a byte whenever a transfer is due.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int EW = 8;
    localparam int MB = 16;

    logic              clk_i = 1'b0;
    logic              srst_i;
    logic [NR*EW-1:0]  req_data_i;
    logic [NR-1:0]     req_valid_i;
    logic [NR-1:0]     req_last_i;
    logic [NR-1:0]     req_ready_o;
    logic [EW-1:0]     out_data_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [NR-1:0]     grant_o;
    logic              busy_o;

    uart_tx_arbiter #(.NUM_REQ(NR), .ELEM_WIDTH(EW), .MAX_BURST(MB)) dut (
        .clk_i       (clk_i),
        .srst_i      (srst_i),
        .req_data_i  (req_data_i),
        .req_valid_i (req_valid_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // stimulus state
    int   q_ent [NR][$];      // bit 8 = last, bits 7:0 = byte
    int   sent  [NR][$];
    int   stall [NR];
    bit   ready_script [$];
    int   valid_pct = 100;
    int   ready_pct = 100;
    bit   rst_req   = 1'b0;
    bit   chk_en    = 1'b0;

    bit          drv_valid [NR];
    logic [7:0]  drv_data  [NR];
    bit          drv_last  [NR];

    // reference model
    int m_owner = -1;
    int m_beats = 0;
    int m_ptr   = 0;
    int cyc     = 0;

    // observation logs
    int rx_log [$];
    int rx_req [$];
    int rx_cyc [$];
    int grant_cycles [NR];
    int r1_leak = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < NR; k++)
            if (q_ent[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int at(input int idx, input bit want_req);
        if (idx >= rx_log.size()) return -1;
        return want_req ? rx_req[idx] : rx_log[idx];
    endfunction

    task automatic clear_logs();
        rx_log.delete();
        rx_req.delete();
        rx_cyc.delete();
        for (int k = 0; k < NR; k++) grant_cycles[k] = 0;
        r1_leak = 0;
    endtask

    task automatic cycle();
        logic [NR-1:0] e_grant;
        logic [NR-1:0] e_ready;
        logic          e_valid;
        logic [7:0]    e_data;
        bit            found;
        int            e;

        for (int k = 0; k < NR; k++) begin
            drv_valid[k] = (q_ent[k].size() > 0) && (stall[k] == 0) &&
                           ($urandom_range(99) < valid_pct);
            if (stall[k] > 0) stall[k]--;
            drv_data[k] = drv_valid[k] ? 8'(q_ent[k][0]) : 8'($urandom);
            drv_last[k] = drv_valid[k] ? q_ent[k][0][8] : 1'($urandom);
            req_data_i[k*EW +: EW] = drv_data[k];
            req_valid_i[k]         = drv_valid[k];
            req_last_i[k]          = drv_last[k];
        end
        if (ready_script.size() > 0) out_ready_i = ready_script.pop_front();
        else                         out_ready_i = ($urandom_range(99) < ready_pct);
        srst_i = rst_req;

        @(negedge clk_i);

        e_grant = '0;
        e_ready = '0;
        e_valid = 1'b0;
        e_data  = '0;
        if (m_owner >= 0) begin
            e_grant = NR'(1 << m_owner);
            e_data  = drv_data[m_owner];
            e_valid = drv_valid[m_owner] && !rst_req;
            if (!rst_req) e_ready = NR'(32'(out_ready_i) << m_owner);
        end
        if (chk_en) begin
            chk("grant", 32'(grant_o), 32'(e_grant));
            chk("busy", 32'(busy_o), 32'(m_owner >= 0));
            chk("out_valid", 32'(out_valid_o), 32'(e_valid));
            chk("out_data", 32'(out_data_o), 32'(e_data));
            chk("req_ready", 32'(req_ready_o), 32'(e_ready));
        end
        for (int k = 0; k < NR; k++)
            if (grant_o == NR'(1 << k)) grant_cycles[k]++;
        if (req_ready_o[1] && q_ent[0].size() > 0) r1_leak++;

        if (rst_req) begin
            m_owner = -1;
            m_ptr   = 0;
            m_beats = 0;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int i = 0; i < NR; i++) begin
                if (!found && drv_valid[(m_ptr + i) % NR]) begin
                    found   = 1'b1;
                    m_owner = (m_ptr + i) % NR;
                    m_beats = 0;
                end
            end
        end else if (drv_valid[m_owner] && out_ready_i) begin
            e = q_ent[m_owner].pop_front();
            rx_log.push_back(e & 255);
            rx_req.push_back(m_owner);
            rx_cyc.push_back(cyc);
            m_beats++;
            if (e[8] || m_beats == MB) begin
                m_ptr   = (m_owner + 1) % NR;
                m_owner = -1;
            end
        end
        cyc++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        for (int k = 0; k < NR; k++) begin
            q_ent[k].delete();
            stall[k] = 0;
        end
        ready_script.delete();
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
        clear_logs();
    endtask

    task automatic drain(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (n < max_cyc && !(all_empty() && m_owner < 0)) begin
            cycle();
            n++;
        end
        chk(tag, 32'(all_empty() && m_owner < 0), 32'd1);
    endtask

    task automatic run_until_rx(input int target, input int max_cyc, input string tag);
        int n;
        n = 0;
        while (n < max_cyc && rx_log.size() < target) begin
            cycle();
            n++;
        end
        chk(tag, 32'(rx_log.size() >= target), 32'd1);
    endtask

    task automatic push_pkt(input int k, input int first, input int len);
        for (int i = 0; i < len; i++)
            q_ent[k].push_back(((first + i) & 255) | ((i == len - 1) ? 256 : 0));
    endtask

    initial begin
        int exp_order [8];
        int mism;
        int idx;
        int len;
        int b;
        int total_sent;

        for (int k = 0; k < NR; k++) stall[k] = 0;
        srst_i      = 1'b1;
        out_ready_i = 1'b0;
        req_valid_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;

        // power-on reset, outputs unknown until the first edge
        rst_req = 1'b1;
        cycle();
        cycle();
        rst_req = 1'b0;
        chk_en  = 1'b1;
        cycle();
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_grant", 32'(grant_o), 32'd0);
        clear_logs();

        // single requester, three-byte packet
        valid_pct = 100;
        ready_pct = 100;
        q_ent[1].push_back(8'hA1);
        q_ent[1].push_back(8'hA2);
        q_ent[1].push_back(8'hA3 | 256);
        drain(20, "single_drain");
        chk("single_cnt", 32'(rx_log.size()), 32'd3);
        chk("single_b0", 32'(at(0, 0)), 32'hA1);
        chk("single_b1", 32'(at(1, 0)), 32'hA2);
        chk("single_b2", 32'(at(2, 0)), 32'hA3);
        chk("single_gcyc", 32'(grant_cycles[1]), 32'd3);
        chk("single_busy_end", 32'(busy_o), 32'd0);

        // pointer now 2: req2 beats req0 when both arrive together
        clear_logs();
        q_ent[0].push_back(8'hB0 | 256);
        q_ent[2].push_back(8'hC0 | 256);
        drain(20, "ptr_drain");
        chk("ptr_first", 32'(at(0, 1)), 32'd2);
        chk("ptr_second", 32'(at(1, 1)), 32'd0);

        // contention from reset
        do_reset();
        push_pkt(0, 8'h10, 2);
        push_pkt(0, 8'h12, 2);
        push_pkt(2, 8'h20, 2);
        push_pkt(2, 8'h22, 2);
        drain(40, "cont_drain");
        exp_order = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h12, 8'h13, 8'h22, 8'h23};
        mism = 0;
        for (int i = 0; i < 8; i++)
            if (at(i, 0) != exp_order[i]) mism++;
        chk("cont_order", 32'(mism), 32'd0);
        if (rx_cyc.size() >= 3)
            chk("cont_bubble", 32'(rx_cyc[2] - rx_cyc[1]), 32'd2);
        else
            chk("cont_bubble_cnt", 32'(rx_cyc.size()), 32'd8);

        // burst limit: 20-byte packet with MAX_BURST = 16
        do_reset();
        push_pkt(3, 0, 20);
        drain(60, "burst_drain");
        chk("burst_cnt", 32'(rx_log.size()), 32'd20);
        mism = 0;
        for (int i = 0; i < 20; i++)
            if (at(i, 0) != i || at(i, 1) != 3) mism++;
        chk("burst_order", 32'(mism), 32'd0);
        if (rx_cyc.size() >= 17) begin
            chk("burst_first16", 32'(rx_cyc[15] - rx_cyc[0]), 32'd15);
            chk("burst_rearb", 32'(rx_cyc[16] - rx_cyc[15]), 32'd2);
        end else begin
            chk("burst_short", 32'(rx_cyc.size()), 32'd20);
        end

        // backpressure on a two-byte packet
        do_reset();
        push_pkt(0, 8'h55, 2);
        ready_script.push_back(1'b1);   // idle cycle
        ready_script.push_back(1'b1);
        ready_script.push_back(1'b0);
        ready_script.push_back(1'b0);
        ready_script.push_back(1'b1);
        drain(20, "bp_drain");
        chk("bp_cnt", 32'(rx_log.size()), 32'd2);
        chk("bp_b0", 32'(at(0, 0)), 32'h55);
        chk("bp_b1", 32'(at(1, 0)), 32'h56);
        if (rx_cyc.size() >= 2)
            chk("bp_gap", 32'(rx_cyc[1] - rx_cyc[0]), 32'd3);

        // reset after 2 of 5 bytes
        do_reset();
        push_pkt(1, 8'h30, 5);
        run_until_rx(2, 20, "mid_rx2");
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
        q_ent[1].delete();
        chk("mid_busy", 32'(busy_o), 32'd0);
        chk("mid_grant", 32'(grant_o), 32'd0);
        chk("mid_valid", 32'(out_valid_o), 32'd0);
        chk("mid_ready", 32'(req_ready_o), 32'd0);
        chk("mid_data", 32'(out_data_o), 32'd0);
        chk("mid_no_third", 32'(rx_log.size()), 32'd2);
        q_ent[2].push_back(8'h40 | 256);
        q_ent[3].push_back(8'h50 | 256);
        drain(20, "mid_drain");
        chk("mid_after_first", 32'(at(2, 1)), 32'd2);
        chk("mid_after_second", 32'(at(3, 1)), 32'd3);

        // granted requester stalls mid-packet while another waits
        do_reset();
        push_pkt(0, 8'h60, 4);
        push_pkt(1, 8'h70, 1);
        run_until_rx(1, 20, "stall_rx1");
        stall[0] = 10;
        drain(60, "stall_drain");
        mism = 0;
        for (int i = 0; i < 4; i++)
            if (at(i, 1) != 0) mism++;
        chk("stall_order", 32'(mism), 32'd0);
        chk("stall_req1_last", 32'(at(4, 1)), 32'd1);
        chk("stall_no_leak", 32'(r1_leak), 32'd0);
        chk("stall_held", 32'(grant_cycles[0] >= 13), 32'd1);

        // randomized traffic
        do_reset();
        total_sent = 0;
        for (int k = 0; k < NR; k++) begin
            sent[k].delete();
            for (int p = 0; p < 5; p++) begin
                len = $urandom_range(1, 24);
                for (int i = 0; i < len; i++) begin
                    b = $urandom_range(0, 255);
                    sent[k].push_back(b);
                    q_ent[k].push_back(b | ((i == len - 1) ? 256 : 0));
                    total_sent++;
                end
            end
        end
        valid_pct = 70;
        ready_pct = 70;
        for (int i = 0; i < 1500; i++) cycle();
        valid_pct = 100;
        ready_pct = 100;
        drain(3000, "rand_drain");
        chk("rand_total", 32'(rx_log.size()), 32'(total_sent));
        for (int k = 0; k < NR; k++) begin
            mism = 0;
            idx  = 0;
            for (int i = 0; i < rx_log.size(); i++) begin
                if (rx_req[i] == k) begin
                    if (idx >= sent[k].size() || rx_log[i] != sent[k][idx]) mism++;
                    idx++;
                end
            end
            chk($sformatf("rand_order_%0d", k), 32'(mism), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
